graph_memory_responder: RTL and testbench
=========================================

// Module: graph_memory_responder
// PURPOSE
//  Memory-side responder for the edge-fetch read interface used by the edge-cache initiator.
//  Holds the flattened adjacency matrix (row-major, one word per edge) in internal storage.
//  Serves one read at a time with a fixed, parameterised latency.
//  A load port lets the testbench or host fill the matrix before or between searches.
//  Sits between the Dijkstra datapath and the graph store; it is also the reference model in benches.
// PARAMETERS
//  MADDR_WIDTH   `DEFAULT_MADDR_WIDTH  byte-address width of mem_addr/load_addr
//  MDATA_WIDTH   `DEFAULT_MDATA_WIDTH  word width; must be a multiple of 8
//  DEPTH         256                   words of storage (>= MAX_NODES*MAX_NODES)
//  READ_LATENCY  2                     cycles from request accept to ready pulse; legal range 1..15
// PORTS
//  clock            in   1            rising-edge clock
//  reset            in   1            synchronous, active-high
//  mem_addr         in   MADDR_WIDTH  byte address of requested word
//  mem_read_enable  in   1            read request (level; sampled only in IDLE)
//  mem_data         out  MDATA_WIDTH  read data; valid only while mem_read_ready=1
//  mem_read_ready   out  1            one-cycle pulse: mem_data/mem_error valid
//  mem_error        out  1            qualifies mem_read_ready: address out of range
//  load_enable      in   1            write strobe for the load port
//  load_addr        in   MADDR_WIDTH  byte address of word to write
//  load_data        in   MDATA_WIDTH  word to write
//  busy             out  1            1 in WAIT/RESPOND, i.e. request in flight
//  read_count       out  16           accepted reads since reset; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: mem_data=0, mem_read_ready=0, mem_error=0, busy=0, read_count=0, state=IDLE.
//   Storage contents are NOT cleared. Reset mid-request aborts it; no ready pulse is issued.
//  Word index = mem_addr >> log2(MDATA_WIDTH/8); low address bits are ignored (no misalignment error).
//  FSM:
//   IDLE:    if mem_read_enable at edge T -> capture index and storage word, read_count++.
//            If READ_LATENCY==1 go to RESPOND, else go to WAIT with down-counter = READ_LATENCY-1.
//   WAIT:    decrement the counter; at zero go to RESPOND.
//   RESPOND: mem_read_ready=1 for exactly one cycle, from edge T+READ_LATENCY to T+READ_LATENCY+1.
//            mem_read_enable is ignored in this cycle; return to IDLE.
//  Throughput: at most one accept per READ_LATENCY+1 cycles.
//   An initiator holding enable high gets back-to-back reads at that rate.
//  mem_data/mem_error are driven only in the RESPOND cycle. Otherwise mem_data=0 and mem_error=0.
//  Out of range (index >= DEPTH): respond with the normal latency, mem_data = all ones (infinite weight),
//   mem_error=1.
//  Data is snapshotted at accept. A load to the same index in the accept cycle or later is not visible;
//   a load at edge T-1 is.
//  Load port:
//   - single-cycle write at the edge where load_enable=1, independent of FSM state;
//   - out-of-range load_addr is silently dropped.
//  Simultaneous load and read accept in the same cycle: both happen; the read returns old data.
//  mem_addr is sampled only at accept; it may change while busy.
//  read_count increments for out-of-range accepts too.
// STRUCTURE
//  Add to constants.v: `DEFAULT_GRAPH_DEPTH (256), `DEFAULT_READ_LATENCY (2), `INFINITE_WEIGHT (all ones).
//  Sub-module graph_mem_array holds the storage: DEPTH x MDATA_WIDTH, synchronous write, combinational read.
//   Instantiate once; the FSM, latency counter and response registers live in the top module.
//  State encoding: 2-bit localparams IDLE/WAIT/RESPOND.
// TESTING (MDATA_WIDTH=32, DEPTH=16, READ_LATENCY=2 unless noted)
//  1. Load addr 0x08 <- 0x0000_0007, then pulse enable with addr 0x08 at edge T
//     -> ready=1 at T+2 only, data=7, error=0, read_count=1.
//  2. Hold enable high with addr 0x0C (holds 5) for 9 cycles
//     -> ready pulses at T+2, T+5, T+8, each with data=5; read_count=3.
//  3. Read addr 0x40 (index 16 >= DEPTH) -> ready at T+2, data=0xFFFF_FFFF, error=1. Load to 0x40 leaves storage unchanged.
//  4. Accept read of index 3 (holds 1) while a load writes 9 to index 3 in the same cycle
//     -> response data=1; the next read returns 9.
//  5. Accept a read, assert reset at T+1 -> no ready pulse; busy=0, read_count=0, storage retains prior words.
//  6. READ_LATENCY=1: enable held high -> ready every 2nd cycle. Address 0x09 reads index 2 (low bits ignored).

Source files
------------

// File: rtl/graph_memory_responder_pkg.sv
// Shared constants and types for the graph memory responder: default
// geometry of the adjacency store, the FSM state type and the helper that
// turns a byte address into a word index.
package graph_memory_responder_pkg;

   // Default geometry of the edge-fetch interface and the graph store.
   localparam int DEFAULT_MADDR_WIDTH  = 16;
   localparam int DEFAULT_MDATA_WIDTH  = 32;
   localparam int DEFAULT_GRAPH_DEPTH  = 256;
   localparam int DEFAULT_READ_LATENCY = 2;

   // The latency down-counter covers READ_LATENCY values 1..15.
   localparam int LATENCY_COUNT_WIDTH = 4;

   // Responder FSM: IDLE accepts, WAIT burns latency, RESPOND arms the
   // one-cycle ready pulse.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      RESPOND = 2'd2
   } state_t;

   // Number of low byte-address bits that select a byte inside one word.
   function automatic int word_shift(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/graph_memory_responder_mem_array.sv
// Adjacency-matrix storage for the graph memory responder: DEPTH words of
// WIDTH bits, written synchronously through the load port and read
// combinationally so the responder can snapshot a word at accept time.
module graph_mem_array #(
   parameter int DEPTH       = 256,
   parameter int WIDTH       = 32,
   parameter int INDEX_WIDTH = 8
) (
   input  logic                   clock,
   input  logic                   write_enable,
   input  logic [INDEX_WIDTH-1:0] write_index,
   input  logic [WIDTH-1:0]       write_data,
   input  logic [INDEX_WIDTH-1:0] read_index,
   output logic [WIDTH-1:0]       read_data
);

   logic [WIDTH-1:0] storage [DEPTH];

   // Single-cycle word write from the load port.
   // NOTE: the storage array has no reset; graph contents must survive a
   // responder reset, and a reset loop over every word would also stop the
   // array mapping onto RAM.
   always_ff @(posedge clock) begin
      if (write_enable) begin
         storage[write_index] <= write_data;
      end
   end

   assign read_data = storage[read_index];

endmodule

// File: rtl/graph_memory_responder.sv
// Memory-side responder for the edge-fetch read interface. Serves one read
// at a time from the flattened adjacency matrix with a fixed latency,
// flags out-of-range word indices with an all-ones (infinite) weight, and
// accepts host writes through an independent load port.
module graph_memory_responder
   import graph_memory_responder_pkg::*;
#(
   parameter int MADDR_WIDTH  = DEFAULT_MADDR_WIDTH,
   parameter int MDATA_WIDTH  = DEFAULT_MDATA_WIDTH,
   parameter int DEPTH        = DEFAULT_GRAPH_DEPTH,
   parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [MADDR_WIDTH-1:0] mem_addr,
   input  logic                   mem_read_enable,
   output logic [MDATA_WIDTH-1:0] mem_data,
   output logic                   mem_read_ready,
   output logic                   mem_error,
   input  logic                   load_enable,
   input  logic [MADDR_WIDTH-1:0] load_addr,
   input  logic [MDATA_WIDTH-1:0] load_data,
   output logic                   busy,
   output logic [15:0]            read_count
);

   localparam int SHIFT       = word_shift(MDATA_WIDTH);
   localparam int INDEX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [LATENCY_COUNT_WIDTH-1:0] WAIT_LOAD =
      LATENCY_COUNT_WIDTH'(READ_LATENCY - 1);

   state_t                         state;
   state_t                         state_next;
   logic [LATENCY_COUNT_WIDTH-1:0] wait_count;
   logic [LATENCY_COUNT_WIDTH-1:0] wait_count_next;

   logic [MADDR_WIDTH-1:0] read_word_index;
   logic [MADDR_WIDTH-1:0] load_word_index;
   logic                   read_in_range;
   logic                   load_in_range;
   logic [MDATA_WIDTH-1:0] array_read_data;
   logic                   accept;

   logic [MDATA_WIDTH-1:0] held_word;
   logic                   held_error;

   // Byte addresses become word indices; the low byte-lane bits are dropped
   // without any misalignment check.
   assign read_word_index = mem_addr >> SHIFT;
   assign load_word_index = load_addr >> SHIFT;
   assign read_in_range   = 32'(read_word_index) < 32'(DEPTH);
   assign load_in_range   = 32'(load_word_index) < 32'(DEPTH);

   // A request is only taken while idle; enable is ignored while busy.
   assign accept = (state == IDLE) && mem_read_enable;
   assign busy   = (state != IDLE);

   graph_mem_array #(
      .DEPTH       (DEPTH),
      .WIDTH       (MDATA_WIDTH),
      .INDEX_WIDTH (INDEX_WIDTH)
   ) u_mem_array (
      .clock        (clock),
      .write_enable (load_enable && load_in_range),
      .write_index  (load_word_index[INDEX_WIDTH-1:0]),
      .write_data   (load_data),
      .read_index   (read_word_index[INDEX_WIDTH-1:0]),
      .read_data    (array_read_data)
   );

   // State register and latency down-counter.
   // NOTE: every clocked block uses non-blocking assignments so all
   // registers sample pre-edge values; blocking here would let later
   // statements see already-updated state and create ordering races.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         wait_count <= '0;
      end else begin
         state      <= state_next;
         wait_count <= wait_count_next;
      end
   end

   // Next-state logic: accept in IDLE, count latency in WAIT, hand over to
   // the response registers from RESPOND.
   // NOTE: both outputs are defaulted before the case so no path leaves them
   // unassigned; a missing default would infer latches.
   always_comb begin
      state_next      = state;
      wait_count_next = wait_count;
      case (state)
         IDLE: begin
            if (mem_read_enable) begin
               if (READ_LATENCY == 1) begin
                  state_next = RESPOND;
               end else begin
                  state_next      = WAIT;
                  wait_count_next = WAIT_LOAD;
               end
            end
         end
         WAIT: begin
            wait_count_next = wait_count - 1'b1;
            if (wait_count_next == '0) begin
               state_next = RESPOND;
            end
         end
         RESPOND: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Snapshot the word at accept so later loads to the same index cannot
   // leak into this response. These holding registers need no reset: they
   // are only observed after a fresh accept has overwritten them.
   always_ff @(posedge clock) begin
      if (accept) begin
         held_word  <= read_in_range ? array_read_data : '1;
         held_error <= !read_in_range;
      end
   end

   // Response registers: data and error are driven only alongside the
   // one-cycle ready pulse and are zero otherwise.
   always_ff @(posedge clock) begin
      if (reset) begin
         mem_read_ready <= 1'b0;
         mem_data       <= '0;
         mem_error      <= 1'b0;
      end else begin
         mem_read_ready <= (state == RESPOND);
         mem_data       <= (state == RESPOND) ? held_word : '0;
         mem_error      <= (state == RESPOND) && held_error;
      end
   end

   // Saturating count of accepted reads, out-of-range ones included.
   always_ff @(posedge clock) begin
      if (reset) begin
         read_count <= '0;
      end else if (accept && (read_count != 16'hFFFF)) begin
         read_count <= read_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_graph_memory_responder.sv
// Self-checking bench for graph_memory_responder: a directed vector table,
// hand-written multi-cycle sequences, a READ_LATENCY=1 instance and a
// randomized run against a behavioural model.
module tb_graph_memory_responder;

   logic        clock;
   logic        reset;
   logic [15:0] mem_addr;
   logic        mem_read_enable;
   logic [31:0] mem_data;
   logic        mem_read_ready;
   logic        mem_error;
   logic        load_enable;
   logic [15:0] load_addr;
   logic [31:0] load_data;
   logic        busy;
   logic [15:0] read_count;

   logic [15:0] f_mem_addr;
   logic        f_mem_read_enable;
   logic [31:0] f_mem_data;
   logic        f_mem_read_ready;
   logic        f_mem_error;
   logic        f_load_enable;
   logic [15:0] f_load_addr;
   logic [31:0] f_load_data;
   logic        f_busy;
   logic [15:0] f_read_count;

   int checks = 0;
   int errors = 0;

   graph_memory_responder #(
      .MADDR_WIDTH (16), .MDATA_WIDTH (32), .DEPTH (16), .READ_LATENCY (2)
   ) dut (
      .clock (clock), .reset (reset),
      .mem_addr (mem_addr), .mem_read_enable (mem_read_enable),
      .mem_data (mem_data), .mem_read_ready (mem_read_ready),
      .mem_error (mem_error), .load_enable (load_enable),
      .load_addr (load_addr), .load_data (load_data),
      .busy (busy), .read_count (read_count)
   );

   graph_memory_responder #(
      .MADDR_WIDTH (16), .MDATA_WIDTH (32), .DEPTH (16), .READ_LATENCY (1)
   ) dut_fast (
      .clock (clock), .reset (reset),
      .mem_addr (f_mem_addr), .mem_read_enable (f_mem_read_enable),
      .mem_data (f_mem_data), .mem_read_ready (f_mem_read_ready),
      .mem_error (f_mem_error), .load_enable (f_load_enable),
      .load_addr (f_load_addr), .load_data (f_load_data),
      .busy (f_busy), .read_count (f_read_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        ld;
      logic [15:0] la;
      logic [31:0] ldat;
      logic        rd;
      logic [15:0] ra;
      logic        e_ready;
      logic [31:0] e_data;
      logic        e_error;
      logic        e_busy;
      logic [15:0] e_count;
   } vec_t;

   typedef struct {
      int          due;
      logic [31:0] data;
      logic        err;
   } resp_t;

   function automatic vec_t mk(input logic ld, input logic [15:0] la,
                               input logic [31:0] ldat, input logic rd,
                               input logic [15:0] ra, input logic e_ready,
                               input logic [31:0] e_data, input logic e_error,
                               input logic e_busy, input logic [15:0] e_count);
      vec_t v;
      v.ld = ld; v.la = la; v.ldat = ldat; v.rd = rd; v.ra = ra;
      v.e_ready = e_ready; v.e_data = e_data; v.e_error = e_error;
      v.e_busy = e_busy; v.e_count = e_count;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_outputs(input string tag, input logic e_ready,
                                input logic [31:0] e_data, input logic e_error,
                                input logic e_busy, input logic [15:0] e_count);
      check({tag, " ready"}, 32'(mem_read_ready), 32'(e_ready));
      check({tag, " data"},  mem_data,            e_data);
      check({tag, " error"}, 32'(mem_error),      32'(e_error));
      check({tag, " busy"},  32'(busy),           32'(e_busy));
      check({tag, " count"}, 32'(read_count),     32'(e_count));
   endtask

   vec_t        vecs [22];
   logic [31:0] model_mem [16];
   resp_t       pend [$];

   initial begin
      // Directed table: each entry holds inputs across one edge and the
      // outputs expected just after it.
      vecs[0]  = mk(1, 16'h08, 32'h7,    0, 16'h00, 0, 32'h0,        0, 0, 0);
      vecs[1]  = mk(1, 16'h0C, 32'h5,    1, 16'h08, 0, 32'h0,        0, 1, 1);
      vecs[2]  = mk(0, 16'h00, 32'h0,    0, 16'h00, 0, 32'h0,        0, 1, 1);
      vecs[3]  = mk(0, 16'h00, 32'h0,    0, 16'h00, 1, 32'h7,        0, 0, 1);
      vecs[4]  = mk(0, 16'h00, 32'h0,    0, 16'h00, 0, 32'h0,        0, 0, 1);
      vecs[5]  = mk(0, 16'h00, 32'h0,    1, 16'h0C, 0, 32'h0,        0, 1, 2);
      vecs[6]  = mk(0, 16'h00, 32'h0,    1, 16'h0C, 0, 32'h0,        0, 1, 2);
      vecs[7]  = mk(0, 16'h00, 32'h0,    1, 16'h0C, 1, 32'h5,        0, 0, 2);
      vecs[8]  = mk(0, 16'h00, 32'h0,    1, 16'h0C, 0, 32'h0,        0, 1, 3);
      vecs[9]  = mk(0, 16'h00, 32'h0,    1, 16'h0C, 0, 32'h0,        0, 1, 3);
      vecs[10] = mk(0, 16'h00, 32'h0,    1, 16'h0C, 1, 32'h5,        0, 0, 3);
      vecs[11] = mk(0, 16'h00, 32'h0,    1, 16'h0C, 0, 32'h0,        0, 1, 4);
      vecs[12] = mk(0, 16'h00, 32'h0,    1, 16'h0C, 0, 32'h0,        0, 1, 4);
      vecs[13] = mk(0, 16'h00, 32'h0,    1, 16'h0C, 1, 32'h5,        0, 0, 4);
      vecs[14] = mk(0, 16'h00, 32'h0,    0, 16'h00, 0, 32'h0,        0, 0, 4);
      vecs[15] = mk(1, 16'h40, 32'h1234, 1, 16'h40, 0, 32'h0,        0, 1, 5);
      vecs[16] = mk(0, 16'h00, 32'h0,    0, 16'h00, 0, 32'h0,        0, 1, 5);
      vecs[17] = mk(0, 16'h00, 32'h0,    0, 16'h00, 1, 32'hFFFFFFFF, 1, 0, 5);
      vecs[18] = mk(0, 16'h00, 32'h0,    0, 16'h00, 0, 32'h0,        0, 0, 5);
      vecs[19] = mk(0, 16'h00, 32'h0,    1, 16'h00, 0, 32'h0,        0, 1, 6);
      vecs[20] = mk(0, 16'h00, 32'h0,    0, 16'h00, 0, 32'h0,        0, 1, 6);
      vecs[21] = mk(0, 16'h00, 32'h0,    0, 16'h00, 1, 32'h100,      0, 0, 6);

      reset = 1'b1;
      mem_addr = '0; mem_read_enable = 1'b0;
      load_enable = 1'b0; load_addr = '0; load_data = '0;
      f_mem_addr = '0; f_mem_read_enable = 1'b0;
      f_load_enable = 1'b0; f_load_addr = '0; f_load_data = '0;
      tick();
      tick();
      check_outputs("reset", 0, 32'h0, 0, 0, 16'h0);
      check("reset fast ready", 32'(f_mem_read_ready), 32'h0);
      check("reset fast count", 32'(f_read_count), 32'h0);
      reset = 1'b0;

      // Preload every word so no read ever returns uninitialised storage.
      for (int i = 0; i < 16; i++) begin
         load_enable = 1'b1;
         load_addr   = 16'(i * 4);
         load_data   = 32'h100 + 32'(i);
         f_load_enable = (i == 0);
         f_load_addr   = 16'h08;
         f_load_data   = 32'hABC;
         tick();
      end
      load_enable = 1'b0;
      f_load_enable = 1'b0;

      for (int i = 0; i < 22; i++) begin
         load_enable     = vecs[i].ld;
         load_addr       = vecs[i].la;
         load_data       = vecs[i].ldat;
         mem_read_enable = vecs[i].rd;
         mem_addr        = vecs[i].ra;
         tick();
         check_outputs($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_data,
                       vecs[i].e_error, vecs[i].e_busy, vecs[i].e_count);
      end
      load_enable = 1'b0;
      mem_read_enable = 1'b0;

      // Load and accept to the same index in one cycle: old data returned.
      load_enable = 1'b1; load_addr = 16'h0C; load_data = 32'h1;
      tick();
      mem_read_enable = 1'b1; mem_addr = 16'h0C; load_data = 32'h9;
      tick();
      check_outputs("same-cycle accept", 0, 32'h0, 0, 1, 16'd7);
      load_enable = 1'b0; mem_read_enable = 1'b0;
      tick();
      tick();
      check_outputs("same-cycle response", 1, 32'h1, 0, 0, 16'd7);
      mem_read_enable = 1'b1;
      tick();
      mem_read_enable = 1'b0;
      tick();
      tick();
      check_outputs("after-load response", 1, 32'h9, 0, 0, 16'd8);

      // Reset one cycle after accept aborts the request.
      mem_read_enable = 1'b1; mem_addr = 16'h08;
      tick();
      check("abort accept count", 32'(read_count), 32'd9);
      mem_read_enable = 1'b0; reset = 1'b1;
      tick();
      check_outputs("abort reset", 0, 32'h0, 0, 0, 16'h0);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("abort no pulse %0d", k), 32'(mem_read_ready), 32'h0);
      end
      mem_read_enable = 1'b1;
      tick();
      mem_read_enable = 1'b0;
      tick();
      tick();
      check_outputs("storage retained", 1, 32'h7, 0, 0, 16'd1);

      // READ_LATENCY=1 instance: ready every second cycle, low bits ignored.
      f_mem_read_enable = 1'b1; f_mem_addr = 16'h09;
      for (int k = 0; k < 6; k++) begin
         tick();
         check($sformatf("fast ready %0d", k), 32'(f_mem_read_ready),
               32'(k % 2 == 1));
         check($sformatf("fast data %0d", k), f_mem_data,
               (k % 2 == 1) ? 32'hABC : 32'h0);
      end
      f_mem_read_enable = 1'b0;
      check("fast count", 32'(f_read_count), 32'd3);

      // Randomized run against the behavioural model.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         model_mem[i] = $urandom;
         load_enable = 1'b1;
         load_addr   = 16'(i * 4);
         load_data   = model_mem[i];
         tick();
      end
      load_enable = 1'b0;
      begin
         int          free_at;
         int          model_count;
         logic        e_ready;
         logic [31:0] e_data;
         logic        e_error;
         int          idx;
         free_at = 0;
         model_count = 0;
         for (int e = 0; e < 400; e++) begin
            load_enable     = ($urandom_range(0, 2) == 0);
            load_addr       = 16'($urandom_range(0, 16'h4F));
            load_data       = $urandom;
            mem_read_enable = ($urandom_range(0, 2) != 0);
            mem_addr        = 16'($urandom_range(0, 16'h4F));
            tick();
            // One accept allowed every latency+1 edges; data seen at accept.
            if (mem_read_enable && e >= free_at) begin
               idx = int'(mem_addr) / 4;
               if (idx < 16) pend.push_back('{e + 2, model_mem[idx], 1'b0});
               else          pend.push_back('{e + 2, 32'hFFFFFFFF, 1'b1});
               free_at = e + 3;
               model_count++;
            end
            if (load_enable && (int'(load_addr) / 4) < 16) begin
               model_mem[int'(load_addr) / 4] = load_data;
            end
            e_ready = 1'b0; e_data = '0; e_error = 1'b0;
            if (pend.size() > 0 && pend[0].due == e) begin
               e_ready = 1'b1;
               e_data  = pend[0].data;
               e_error = pend[0].err;
               void'(pend.pop_front());
            end
            check_outputs($sformatf("rand%0d", e), e_ready, e_data, e_error,
                          (e < free_at - 1), 16'(model_count));
         end
      end
      load_enable = 1'b0;
      mem_read_enable = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
